// File: rtl/vc_test_mem_responder.sv
// Test memory responder: word-organised memory with byte-lane access,
// fixed-latency in-order responses, and optional periodic back-pressure.
module vc_test_mem_responder #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned BURST     = 0,
  parameter int unsigned GAP       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [34:0] memresp_msg,
  output logic        memresp_val,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned ACNT_W = $clog2(BURST + 2);
  localparam int unsigned GCNT_W = 4;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_GAP    = 1'b1
  } state_e;

  logic [31:0]       r_mem [MEM_WORDS];
  state_e            r_state;
  state_e            w_state_nxt;
  logic [ACNT_W-1:0] r_acnt;
  logic [ACNT_W-1:0] w_acnt_nxt;
  logic [GCNT_W-1:0] r_gcnt;
  logic [GCNT_W-1:0] w_gcnt_nxt;
  logic [LATENCY-1:0] r_pipe_val;
  logic [34:0]       r_pipe_msg [LATENCY];

  logic              w_req_type;
  logic [31:0]       w_req_addr;
  logic [1:0]        w_req_len;
  logic [31:0]       w_req_data;
  logic [IDX_W-1:0]  w_req_idx;
  logic [1:0]        w_req_off;
  logic [2:0]        w_nbytes;
  logic [IDX_W-1:0]  w_load_idx;
  logic              w_accept;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_rd_shift;
  logic [31:0]       w_rd_mask;
  logic [31:0]       w_rd_data;
  logic [34:0]       w_resp_msg;
  logic [31:0]       w_wr_base;
  logic [31:0]       w_wr_word;
  logic              w_unused;

  // Request field decode and handshake
  assign w_req_type = memreq_msg[66];
  assign w_req_addr = memreq_msg[65:34];
  assign w_req_len  = memreq_msg[33:32];
  assign w_req_data = memreq_msg[31:0];
  assign w_req_idx  = w_req_addr[IDX_W+1:2];
  assign w_req_off  = w_req_addr[1:0];
  assign w_nbytes   = (w_req_len == 2'd0) ? 3'd4 : {1'b0, w_req_len};
  assign w_load_idx = load_addr[IDX_W+1:2];

  assign memreq_rdy = ~reset & (r_state == ST_ACCEPT);
  assign w_accept   = memreq_val & memreq_rdy;

  // Address bits above the memory size and load byte offset are don't-care
  assign w_unused = ^{w_req_addr[31:IDX_W+2], load_addr[31:IDX_W+2], load_addr[1:0]};

  // Read path: shift the addressed byte down to bit 0, keep nbytes
  assign w_rd_word  = r_mem[w_req_idx];
  assign w_rd_shift = w_rd_word >> {w_req_off, 3'b000};

  // Byte mask for the kept read bytes
  always_comb begin
    w_rd_mask = 32'hFFFF_FFFF;
    case (w_nbytes)
      3'd1:    w_rd_mask = 32'h0000_00FF;
      3'd2:    w_rd_mask = 32'h0000_FFFF;
      3'd3:    w_rd_mask = 32'h00FF_FFFF;
      default: w_rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign w_rd_data  = w_rd_shift & w_rd_mask;
  assign w_resp_msg = {w_req_type, w_req_len, (w_req_type ? 32'd0 : w_rd_data)};

  // Write merge: same-edge load lands first, then the request's byte lanes
  always_comb begin
    logic [1:0] v_j;
    w_wr_base = (load_en && (w_load_idx == w_req_idx)) ? load_data : w_rd_word;
    w_wr_word = w_wr_base;
    v_j       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      v_j = 2'(k) - w_req_off;
      if ((2'(k) >= w_req_off) && ({1'b0, v_j} < w_nbytes)) begin
        w_wr_word[8*k +: 8] = w_req_data[8*v_j +: 8];
      end
    end
  end

  // Memory array: preload port and accepted writes; untouched by reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[w_load_idx] <= load_data;
    end
    if (w_accept && w_req_type) begin
      r_mem[w_req_idx] <= w_wr_word;
    end
  end

  // Fixed-latency response pipeline; message stages stay zero when empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_val <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_pipe_msg[i] <= '0;
      end
    end else begin
      r_pipe_val[0] <= w_accept;
      r_pipe_msg[0] <= w_accept ? w_resp_msg : 35'd0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_pipe_val[i] <= r_pipe_val[i-1];
        r_pipe_msg[i] <= r_pipe_msg[i-1];
      end
    end
  end

  assign memresp_val = r_pipe_val[LATENCY-1] & ~reset;
  assign memresp_msg = memresp_val ? r_pipe_msg[LATENCY-1] : 35'd0;

  // Back-pressure FSM state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCEPT;
      r_acnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acnt  <= w_acnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
    end
  end

  // Back-pressure next state: BURST accepts, then GAP cycles not ready
  always_comb begin
    w_state_nxt = r_state;
    w_acnt_nxt  = r_acnt;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      ST_ACCEPT: begin
        if ((BURST != 0) && w_accept) begin
          if (r_acnt == ACNT_W'(BURST - 1)) begin
            w_state_nxt = ST_GAP;
            w_gcnt_nxt  = GCNT_W'(GAP);
          end else begin
            w_acnt_nxt = r_acnt + ACNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (r_gcnt <= GCNT_W'(1)) begin
          w_state_nxt = ST_ACCEPT;
          w_acnt_nxt  = '0;
          w_gcnt_nxt  = '0;
        end else begin
          w_gcnt_nxt = r_gcnt - GCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_ACCEPT;
      end
    endcase
  end

endmodule
